// File: rtl/io_map_pkg.sv
// Address map and field positions of the board's memory-mapped I/O block.
// Offsets are relative to the I/O base; word indices are offset[11:2].
package io_map_pkg;

  localparam logic [11:0] OffLedr  = 12'h000;
  localparam logic [11:0] OffLedg  = 12'h010;
  localparam logic [11:0] OffHexLo = 12'h020;
  localparam logic [11:0] OffHexHi = 12'h024;
  localparam logic [11:0] OffLcd   = 12'h030;
  localparam logic [11:0] OffSw    = 12'h800;
  localparam logic [11:0] OffKey   = 12'h810;

  localparam logic [9:0] WordLedr  = OffLedr[11:2];
  localparam logic [9:0] WordLedg  = OffLedg[11:2];
  localparam logic [9:0] WordHexLo = OffHexLo[11:2];
  localparam logic [9:0] WordHexHi = OffHexHi[11:2];
  localparam logic [9:0] WordLcd   = OffLcd[11:2];
  localparam logic [9:0] WordSw    = OffSw[11:2];
  localparam logic [9:0] WordKey   = OffKey[11:2];

  // Implemented bits of each writable register image; everything else reads 0.
  localparam logic [31:0] LedrMask = 32'h0001_FFFF;
  localparam logic [31:0] LedgMask = 32'h0000_00FF;
  localparam logic [31:0] HexMask  = 32'h7F7F_7F7F;
  localparam logic [31:0] LcdMask  = 32'h8000_07FF;

  localparam int unsigned LcdOnBit = 31;
  localparam int unsigned LcdRsBit = 10;
  localparam int unsigned LcdRwBit = 9;
  localparam int unsigned LcdEnBit = 8;

  // Replace the enabled bytes of old_w with those of new_w.
  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                           input logic [3:0] be);
    logic [31:0] m;
    m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (new_w & m) | (old_w & ~m);
  endfunction

endpackage

// File: rtl/io_regs.sv
// Memory-mapped I/O registers for the DE2 board wrapper.
//  clk_i, rst_ni        system clock, raw active-low async reset from the switch
//  sw_i, key_i          board switch / push-button pins (unsynchronised)
//  io_addr_i..io_we_i   core data-port request; io_rdata_o combinational read data
//  rst_sync_no          reset with synchronised deassertion, also feeds the core
//  ledr_o..lcd_data_o   register contents driven to the board pins
module io_regs
  import io_map_pkg::*;
#(
  parameter logic [15:0] IO_BASE = 16'h7000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [16:0] sw_i,
  input  logic        key_i,
  input  logic [31:0] io_addr_i,
  input  logic [31:0] io_wdata_i,
  input  logic [3:0]  io_be_i,
  input  logic        io_we_i,
  output logic [31:0] io_rdata_o,
  output logic        rst_sync_no,
  output logic [16:0] ledr_o,
  output logic [7:0]  ledg_o,
  output logic [55:0] hex_o,
  output logic        lcd_on_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic [7:0]  lcd_data_o
);

  // Assert asynchronously, release two edges later.
  logic rst_meta_q, rst_sync_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rst_meta_q <= 1'b0;
      rst_sync_q <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_sync_q <= rst_meta_q;
    end
  end
  assign rst_sync_no = rst_sync_q;

  logic        sel, wr;
  logic [9:0]  word;
  logic        unused_addr;
  assign sel         = (io_addr_i[15:12] == IO_BASE[15:12]);
  assign word        = io_addr_i[11:2];
  assign wr          = sel & io_we_i;
  assign unused_addr = ^{io_addr_i[31:16], io_addr_i[1:0]};

  logic [31:0] ledr_q, ledr_d, ledg_q, ledg_d;
  logic [31:0] hex_lo_q, hex_lo_d, hex_hi_q, hex_hi_d;
  logic [31:0] lcd_q, lcd_d;
  logic [16:0] sw_meta_q, sw_sync_q;
  logic        key_meta_q, key_sync_q;

  always_comb begin
    ledr_d   = ledr_q;
    ledg_d   = ledg_q;
    hex_lo_d = hex_lo_q;
    hex_hi_d = hex_hi_q;
    lcd_d    = lcd_q;
    if (wr) begin
      case (word)
        WordLedr:  ledr_d   = be_merge(ledr_q, io_wdata_i, io_be_i) & LedrMask;
        WordLedg:  ledg_d   = be_merge(ledg_q, io_wdata_i, io_be_i) & LedgMask;
        WordHexLo: hex_lo_d = be_merge(hex_lo_q, io_wdata_i, io_be_i) & HexMask;
        WordHexHi: hex_hi_d = be_merge(hex_hi_q, io_wdata_i, io_be_i) & HexMask;
        WordLcd:   lcd_d    = be_merge(lcd_q, io_wdata_i, io_be_i) & LcdMask;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_sync_q) begin
    if (!rst_sync_q) begin
      ledr_q     <= '0;
      ledg_q     <= '0;
      hex_lo_q   <= '0;
      hex_hi_q   <= '0;
      lcd_q      <= '0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= 1'b0;
      key_sync_q <= 1'b0;
    end else begin
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      hex_lo_q   <= hex_lo_d;
      hex_hi_q   <= hex_hi_d;
      lcd_q      <= lcd_d;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_i;
      key_sync_q <= key_meta_q;
    end
  end

  // Reads see the registers before any same-cycle write lands.
  always_comb begin
    io_rdata_o = '0;
    if (sel) begin
      case (word)
        WordLedr:  io_rdata_o = ledr_q;
        WordLedg:  io_rdata_o = ledg_q;
        WordHexLo: io_rdata_o = hex_lo_q;
        WordHexHi: io_rdata_o = hex_hi_q;
        WordLcd:   io_rdata_o = lcd_q;
        WordSw:    io_rdata_o = {15'b0, sw_sync_q};
        WordKey:   io_rdata_o = {31'b0, ~key_sync_q};
        default:   io_rdata_o = '0;
      endcase
    end
  end

  assign ledr_o     = ledr_q[16:0];
  assign ledg_o     = ledg_q[7:0];
  assign hex_o      = {hex_hi_q[30:24], hex_hi_q[22:16], hex_hi_q[14:8], hex_hi_q[6:0],
                       hex_lo_q[30:24], hex_lo_q[22:16], hex_lo_q[14:8], hex_lo_q[6:0]};
  assign lcd_on_o   = lcd_q[LcdOnBit];
  assign lcd_rs_o   = lcd_q[LcdRsBit];
  assign lcd_rw_o   = lcd_q[LcdRwBit];
  assign lcd_en_o   = lcd_q[LcdEnBit];
  assign lcd_data_o = lcd_q[7:0];

endmodule

// File: rtl/riscv_pipeline.sv
// Stand-in for the pipelined RV32I core so the board slice elaborates on its own.
// It keeps the I/O data port idle: no stores, a constant load address.
//  clk_i, rst_ni   clock and synchronised active-low reset
//  io_*            core data port (request out, io_rdata in)
module riscv_pipeline (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  output logic [3:0]  io_be,
  output logic        io_we,
  input  logic [31:0] io_rdata
);

  logic [31:0] rdata_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else         rdata_q <= io_rdata;
  end

  assign io_addr  = 32'h0000_7800;
  assign io_wdata = rdata_q;
  assign io_be    = 4'h0;
  assign io_we    = 1'b0;

endmodule

// File: rtl/board_wrapper.sv
// DE2 top level: the RV32I core plus its memory-mapped board I/O.
//  CLOCK_27        system clock
//  SW[17]          active-low async reset; SW[16:0] switch inputs
//  KEY             push-button, active-low
//  LEDR, LEDG      red / green LEDs
//  HEX0..HEX7      7-segment patterns {g..a}, driven as stored
//  LCD_*           character LCD control and data
module board_wrapper #(
  parameter logic [15:0] IO_BASE = 16'h7000
) (
  input  logic        CLOCK_27,
  input  logic [17:0] SW,
  input  logic        KEY,
  output logic [16:0] LEDR,
  output logic [7:0]  LEDG,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX2,
  output logic [6:0]  HEX3,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5,
  output logic [6:0]  HEX6,
  output logic [6:0]  HEX7,
  output logic        LCD_EN,
  output logic        LCD_RW,
  output logic        LCD_RS,
  output logic        LCD_ON,
  output logic [7:0]  LCD_DATA
);

  logic [31:0] io_addr, io_wdata, io_rdata;
  logic [3:0]  io_be;
  logic        io_we;
  logic        rst_sync_n;
  logic [55:0] hex;

  riscv_pipeline u_core (
    .clk_i    (CLOCK_27),
    .rst_ni   (rst_sync_n),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .io_be    (io_be),
    .io_we    (io_we),
    .io_rdata (io_rdata)
  );

  io_regs #(
    .IO_BASE (IO_BASE)
  ) u_io_regs (
    .clk_i       (CLOCK_27),
    .rst_ni      (SW[17]),
    .sw_i        (SW[16:0]),
    .key_i       (KEY),
    .io_addr_i   (io_addr),
    .io_wdata_i  (io_wdata),
    .io_be_i     (io_be),
    .io_we_i     (io_we),
    .io_rdata_o  (io_rdata),
    .rst_sync_no (rst_sync_n),
    .ledr_o      (LEDR),
    .ledg_o      (LEDG),
    .hex_o       (hex),
    .lcd_on_o    (LCD_ON),
    .lcd_rs_o    (LCD_RS),
    .lcd_rw_o    (LCD_RW),
    .lcd_en_o    (LCD_EN),
    .lcd_data_o  (LCD_DATA)
  );

  assign HEX0 = hex[6:0];
  assign HEX1 = hex[13:7];
  assign HEX2 = hex[20:14];
  assign HEX3 = hex[27:21];
  assign HEX4 = hex[34:28];
  assign HEX5 = hex[41:35];
  assign HEX6 = hex[48:42];
  assign HEX7 = hex[55:49];

endmodule

// File: tb/tb_board_wrapper.sv
// Bench for board_wrapper. The core's data port is overridden from here so loads and
// stores can be issued directly; expected pins and load data come from a word-level model.
module tb_board_wrapper;

  logic        clk = 1'b0;
  logic [17:0] sw;
  logic        key;
  logic [16:0] ledr;
  logic [7:0]  ledg;
  logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
  logic        lcd_en, lcd_rw, lcd_rs, lcd_on;
  logic [7:0]  lcd_data;

  always #5 clk = ~clk;

  board_wrapper dut (
    .CLOCK_27 (clk),
    .SW       (sw),
    .KEY      (key),
    .LEDR     (ledr),
    .LEDG     (ledg),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .HEX4     (hex4),
    .HEX5     (hex5),
    .HEX6     (hex6),
    .HEX7     (hex7),
    .LCD_EN   (lcd_en),
    .LCD_RW   (lcd_rw),
    .LCD_RS   (lcd_rs),
    .LCD_ON   (lcd_on),
    .LCD_DATA (lcd_data)
  );

  logic [31:0] b_addr = '0, b_wdata = '0;
  logic [3:0]  b_be = '0;
  logic        b_we = 1'b0;

  typedef struct {
    int           due;
    bit           is_rd;
    logic [127:0] exp;
    string        name;
  } item_t;
  item_t sb[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit done = 1'b0;
  bit drain_checked = 1'b0;

  // Model state: register images, pin history, reset progress.
  logic [31:0] m_ledr = '0, m_ledg = '0, m_hexlo = '0, m_hexhi = '0, m_lcd = '0;
  logic [16:0] sw_val, sw_h0, sw_h1, sw_h2;
  logic        key_val, key_h0, key_h1, key_h2;
  logic        rst_val;
  int          since_rel = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    if (a[15:12] != 4'h7) return 32'h0;
    case (off)
      12'h000: return m_ledr;
      12'h010: return m_ledg;
      12'h020: return m_hexlo;
      12'h024: return m_hexhi;
      12'h030: return m_lcd;
      12'h800: return {15'b0, sw_h2};
      12'h810: return {31'b0, ~key_h2};
      default: return 32'h0;
    endcase
  endfunction

  task automatic m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    logic [11:0] off;
    off = {a[11:2], 2'b00};
    if (a[15:12] != 4'h7) return;
    case (off)
      12'h000: m_ledr  = merge(m_ledr, d, be) & 32'h0001_FFFF;
      12'h010: m_ledg  = merge(m_ledg, d, be) & 32'h0000_00FF;
      12'h020: m_hexlo = merge(m_hexlo, d, be) & 32'h7F7F_7F7F;
      12'h024: m_hexhi = merge(m_hexhi, d, be) & 32'h7F7F_7F7F;
      12'h030: m_lcd   = merge(m_lcd, d, be) & 32'h8000_07FF;
      default: ;
    endcase
  endtask

  function automatic logic [127:0] m_pins();
    return {35'b0, m_ledr[16:0], m_ledg[7:0],
            m_hexhi[30:24], m_hexhi[22:16], m_hexhi[14:8], m_hexhi[6:0],
            m_hexlo[30:24], m_hexlo[22:16], m_hexlo[14:8], m_hexlo[6:0],
            m_lcd[31], m_lcd[10], m_lcd[9], m_lcd[8], m_lcd[7:0]};
  endfunction

  function automatic logic [127:0] pins_now();
    return {35'b0, ledr, ledg, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0,
            lcd_on, lcd_rs, lcd_rw, lcd_en, lcd_data};
  endfunction

  // One bus cycle: drive pins and request just after the edge, queue expectations.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                      input logic we, input bit rd_chk, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    sw_h2 = sw_h1; sw_h1 = sw_h0; sw_h0 = sw_val;
    key_h2 = key_h1; key_h1 = key_h0; key_h0 = key_val;
    sw  = {rst_val, sw_val};
    key = key_val;
    if (!rst_val) begin
      m_ledr = '0; m_ledg = '0; m_hexlo = '0; m_hexhi = '0; m_lcd = '0;
      since_rel = 0;
    end else begin
      since_rel++;
    end
    b_addr = a; b_wdata = d; b_be = be; b_we = we;
    force dut.io_addr  = b_addr;
    force dut.io_wdata = b_wdata;
    force dut.io_be    = b_be;
    force dut.io_we    = b_we;
    it.due = cyc; it.is_rd = 1'b0; it.exp = m_pins(); it.name = {nm, "/pins"};
    sb.push_back(it);
    if (rd_chk) begin
      it.is_rd = 1'b1; it.exp = {96'b0, m_read(a)}; it.name = {nm, "/rdata"};
      sb.push_back(it);
    end
    if (we && since_rel >= 3) m_write(a, d, be);
  endtask

  task automatic idle();
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "idle");
  endtask

  // Monitor: compare every expectation in the cycle it falls due.
  always @(negedge clk) begin
    item_t it;
    logic [127:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      it  = sb.pop_front();
      act = it.is_rd ? {96'b0, dut.io_rdata} : pins_now();
      n_cmp++;
      if (it.due != cyc || act !== it.exp) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=%h expected=%h", it.name, cyc, act, it.exp);
      end
    end
    if (done && !drain_checked) begin
      drain_checked = 1'b1;
      n_cmp++;
      if (sb.size() != 0) begin
        n_bad++;
        $display("FAIL drain got=%0d expected=0 pending items", sb.size());
      end
    end
  end

  initial begin
    logic [31:0] a, d, r;
    logic [11:0] off;
    logic [3:0]  be, hi;
    logic        we;
    int          pick;

    sw_val = 17'd17755; key_val = 1'b1; rst_val = 1'b0;
    sw_h0 = sw_val; sw_h1 = sw_val; sw_h2 = sw_val;
    key_h0 = 1'b1; key_h1 = 1'b1; key_h2 = 1'b1;
    sw = {1'b1, sw_val}; key = 1'b1;
    #1 sw = {1'b0, sw_val};

    // Reset held for 100 ns, then released; switches readable afterwards.
    repeat (10) idle();
    rst_val = 1'b1;
    repeat (6) idle();
    step(32'h0000_7800, 32'h0, 4'h0, 1'b0, 1'b1, "sw_after_reset");

    // LEDR store and read back.
    step(32'h0000_7000, 32'h0001_FFFF, 4'hF, 1'b1, 1'b1, "ledr_wr");
    step(32'h0000_7000, 32'h0, 4'h0, 1'b0, 1'b1, "ledr_rd");
    idle();

    // Reset mid-program clears LEDR without an edge; then restart.
    rst_val = 1'b0;
    step(32'h0, 32'h0, 4'h0, 1'b0, 1'b0, "async_rst");
    repeat (2) idle();
    rst_val = 1'b1;
    repeat (6) idle();

    // HEX byte enables.
    step(32'h0000_7020, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "hex_fill");
    step(32'h0000_7020, 32'h4079_1924, 4'b0101, 1'b1, 1'b1, "hex_be");
    step(32'h0000_7022, 32'h0, 4'h0, 1'b0, 1'b1, "hex_rd_misaligned");

    // LCD fields.
    step(32'h0000_7030, 32'h8000_05A4, 4'hF, 1'b1, 1'b1, "lcd_wr");
    step(32'h0000_7030, 32'h0, 4'h0, 1'b0, 1'b1, "lcd_rd");

    // Key press and a store to the read-only switch register.
    key_val = 1'b0;
    repeat (3) idle();
    step(32'h0000_7810, 32'h0, 4'h0, 1'b0, 1'b1, "key_rd");
    step(32'h0000_7800, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, "sw_wr_ignored");
    step(32'h0000_7800, 32'h0, 4'h0, 1'b0, 1'b1, "sw_rd");

    // Randomised traffic, including misaligned and out-of-region addresses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) sw_val = 17'($urandom);
      if ($urandom_range(0, 15) == 0) key_val = ~key_val;
      r    = $urandom;
      d    = $urandom;
      pick = int'($urandom_range(0, 8));
      case (pick)
        0:       off = 12'h000;
        1:       off = 12'h010;
        2:       off = 12'h020;
        3:       off = 12'h024;
        4:       off = 12'h030;
        5:       off = 12'h800;
        6:       off = 12'h810;
        default: off = 12'($urandom_range(0, 12'hFFF));
      endcase
      a = {r[31:16], 4'h7, off[11:2], r[1:0]};
      if (pick == 8) begin
        hi = 4'($urandom_range(0, 14));
        if (hi >= 4'h7) hi = hi + 4'h1;
        a[15:12] = hi;
      end
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom);
      step(a, d, be, we, 1'b1, $sformatf("rand_%h", a));
    end

    repeat (2) idle();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
